// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that lets NUM_REQ requesters share
// a single FIFO write port. Each grant lasts up to BURST_LEN beats and ends
// early on req_last or when the granted requester drops its valid.
// Optional build macro FIFO_WR_ARB_STALL_CNT_EN adds a 16-bit saturating
// stall_cnt output. It counts cycles spent in BURST where the granted
// requester has data but the FIFO is full.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no grant; a pending request is arbitrated and registered here
// BURST | grant_id owns the write port; beats flow while FIFO not full
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                          wclk,
  input  logic                          wrst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
`ifdef FIFO_WR_ARB_STALL_CNT_EN
  output logic [15:0]                   stall_cnt,
`endif
  output logic                          busy
);

  localparam int GW = $clog2(NUM_REQ);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  localparam logic [7:0]    BURST_LEN_B = 8'(BURST_LEN);
  // Parking the grant on the last index makes requester 0 the first winner.
  localparam logic [GW-1:0] GRANT_RST   = GW'(NUM_REQ - 1);

  logic [0:0]           r_state;
  logic [GW-1:0]        r_grant_id;
  logic [7:0]           r_beat_cnt;

  logic [NUM_REQ-1:0]   w_gnt_onehot;
  logic [DATA_WIDTH-1:0] w_gnt_data;
  logic                 w_gnt_valid;
  logic                 w_gnt_last;
  logic                 w_in_burst;
  logic                 w_beat;
  logic [7:0]           w_beat_cnt_inc;
  logic                 w_burst_done;

  logic [2*NUM_REQ-1:0] w_rr_dbl;
  logic [NUM_REQ-1:0]   w_rr_rot;
  logic                 w_rr_any;
  logic [GW-1:0]        w_rr_winner;

  // Decode the registered grant into a one-hot mask and pick its data/last.
  always_comb begin
    w_gnt_onehot = '0;
    w_gnt_data   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant_id == GW'(i)) begin
        w_gnt_onehot[i] = 1'b1;
        w_gnt_data      = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_gnt_valid = |(req_valid & w_gnt_onehot);
  assign w_gnt_last  = |(req_last & w_gnt_onehot);
  assign w_in_burst  = (r_state == ST_BURST);

  // A stalled beat (fifo_full) is neither counted nor written, so the word
  // stays on the requester side until the FIFO drains.
  assign w_beat         = w_in_burst && w_gnt_valid && !fifo_full;
  assign w_beat_cnt_inc = r_beat_cnt + 8'd1;

  // Burst ends on a final beat (last or length reached) or when the owner
  // withdraws; a full FIFO with valid high never ends it.
  assign w_burst_done = (w_beat && (w_gnt_last || (w_beat_cnt_inc == BURST_LEN_B)))
                        || !w_gnt_valid;

  // Round-robin search: rotate the request vector so the entry just after
  // the previous grant sits at bit 0, then take the lowest set bit.
  always_comb begin
    w_rr_dbl    = {req_valid, req_valid};
    w_rr_rot    = NUM_REQ'(w_rr_dbl >> (int'(r_grant_id) + 1));
    w_rr_any    = 1'b0;
    w_rr_winner = r_grant_id;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (w_rr_rot[j]) begin
        w_rr_any    = 1'b1;
        w_rr_winner = GW'((int'(r_grant_id) + 1 + j) % NUM_REQ);
      end
    end
  end

  // Grant FSM with beat counter; reset abandons any burst in progress.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_state    <= ST_IDLE;
      r_grant_id <= GRANT_RST;
      r_beat_cnt <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rr_any) begin
            r_grant_id <= w_rr_winner;
            r_beat_cnt <= 8'd0;
            r_state    <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (w_beat) begin
            r_beat_cnt <= w_beat_cnt_inc;
          end
          if (w_burst_done) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef FIFO_WR_ARB_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Count back-pressure cycles seen by the granted requester, saturating.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_stall_cnt <= 16'd0;
    end else if (w_in_burst && w_gnt_valid && fifo_full && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

  // Ready only goes to the owner, and only when the FIFO can take a word.
  assign req_ready  = (w_in_burst && !fifo_full) ? w_gnt_onehot : '0;
  assign fifo_w_en  = w_beat;
  assign fifo_wdata = w_gnt_data;
  assign grant_id   = r_grant_id;
  assign busy       = w_in_burst;

  // At most one requester may be offered the write port at a time.
  a_ready_onehot0: assert property (@(posedge wclk) disable iff (wrst)
    $onehot0(req_ready));

  // A FIFO write implies an active grant with room in the FIFO.
  a_wen_in_burst: assert property (@(posedge wclk) disable iff (wrst)
    fifo_w_en |-> (busy && !fifo_full));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int BL = 4;

  logic              wclk;
  logic              wrst;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_last;
  logic [NR-1:0]     req_ready;
  logic              fifo_full;
  logic              fifo_w_en;
  logic [DW-1:0]     fifo_wdata;
  logic [1:0]        grant_id;
  logic              busy;
`ifdef FIFO_WR_ARB_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .wclk       (wclk),
    .wrst       (wrst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_w_en  (fifo_w_en),
    .fifo_wdata (fifo_wdata),
    .grant_id   (grant_id),
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    .stall_cnt  (stall_cnt),
`endif
    .busy       (busy)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  // Requester word queues: bit 8 = last flag, bits 7:0 = data.
  logic [8:0]    rq [NR][$];
  logic [7:0]    wlog [$];
  int            glog [$];
  logic [NR-1:0] en_mask;
  logic          full_drv;
  int            checks;
  int            errors;

  // Expected round-robin winner: first pending index after the previous grant.
  function automatic int rr_pick(input int last, input logic [NR-1:0] v);
    for (int k = 1; k <= NR; k++) begin
      if (v[(last + k) % NR]) return (last + k) % NR;
    end
    return last;
  endfunction

  task automatic apply_inputs();
    logic [8:0] h;
    for (int i = 0; i < NR; i++) begin
      if (rq[i].size() > 0 && en_mask[i]) begin
        h = rq[i][0];
        req_valid[i]         = 1'b1;
        req_data[i*DW +: DW] = h[7:0];
        req_last[i]          = h[8];
      end else begin
        req_valid[i]         = 1'b0;
        req_data[i*DW +: DW] = '0;
        req_last[i]          = 1'b0;
      end
    end
    fifo_full = full_drv;
  endtask

  task automatic drive();
    @(negedge wclk);
    apply_inputs();
    #1;
  endtask

  // Retire handshaken words and log FIFO writes; called just before posedge.
  task automatic commit();
    for (int i = 0; i < NR; i++) begin
      if (req_valid[i] && req_ready[i]) void'(rq[i].pop_front());
    end
    if (fifo_w_en) begin
      wlog.push_back(fifo_wdata);
      glog.push_back(int'(grant_id));
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < NR; i++) rq[i].delete();
    wlog.delete();
    glog.delete();
    en_mask  = '1;
    full_drv = 1'b0;
  endtask

  task automatic push_pkt(input int r, input int n, input bit with_last, input int base);
    for (int k = 0; k < n; k++) begin
      rq[r].push_back({(with_last && (k == n - 1)), 8'(base + k)});
    end
  endtask

  task automatic do_reset();
    wrst = 1'b1;
    clear_all();
    apply_inputs();
    repeat (2) @(posedge wclk);
    @(negedge wclk);
    wrst = 1'b0;
  endtask

  task automatic test_reset();
    clear_all();
    wrst = 1'b1;
    push_pkt(0, 2, 0, 0); push_pkt(1, 2, 0, 0);
    apply_inputs();
    repeat (2) @(posedge wclk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    checks++; if (fifo_w_en !== 1'b0) begin errors++; $display("FAIL reset_wen got %0b exp 0", fifo_w_en); end
    checks++; if (grant_id !== 2'd3) begin errors++; $display("FAIL reset_grant got %0d exp 3", grant_id); end
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall got %0d exp 0", stall_cnt); end
`endif
    // Release with requesters already pending: first edge after release arbitrates.
    @(negedge wclk);
    wrst = 1'b0;
    @(posedge wclk);
    #1;
    checks++; if (busy !== 1'b1 || grant_id !== 2'd0) begin
      errors++; $display("FAIL reset_first_arb got busy=%0b gid=%0d exp busy=1 gid=0", busy, grant_id);
    end
  endtask

  task automatic test_single_req();
    logic [11:0] wen_tr, busy_tr;
    do_reset();
    push_pkt(0, 6, 0, 8'h10);
    for (int c = 0; c < 12; c++) begin
      drive();
      wen_tr[c]  = fifo_w_en;
      busy_tr[c] = busy;
      commit();
    end
    checks++; if (wen_tr !== 12'b0000_1101_1110) begin errors++; $display("FAIL single_wen_trace got %b exp 000011011110", wen_tr); end
    checks++; if (busy_tr !== 12'b0001_1101_1110) begin errors++; $display("FAIL single_busy_trace got %b exp 000111011110", busy_tr); end
    checks++; if (wlog.size() != 6) begin errors++; $display("FAIL single_count got %0d exp 6", wlog.size()); end
    for (int k = 0; k < wlog.size() && k < 6; k++) begin
      checks++; if (wlog[k] !== 8'(16 + k) || glog[k] != 0) begin
        errors++; $display("FAIL single_word%0d got data=%h gid=%0d exp data=%h gid=0", k, wlog[k], glog[k], 8'(16 + k));
      end
    end
  endtask

  task automatic test_all_valid();
    int b, g;
    logic [7:0] ed;
    do_reset();
    for (int i = 0; i < NR; i++) push_pkt(i, 16, 0, i * 32);
    for (int c = 0; c < 26; c++) begin
      drive();
      commit();
    end
    checks++; if (wlog.size() != 20) begin errors++; $display("FAIL allv_count got %0d exp 20", wlog.size()); end
    for (int k = 0; k < wlog.size() && k < 20; k++) begin
      b  = k / 4;
      g  = b % NR;
      ed = 8'(g * 32 + (b / NR) * 4 + k % 4);
      checks++; if (glog[k] != g || wlog[k] !== ed) begin
        errors++; $display("FAIL allv_write%0d got gid=%0d data=%h exp gid=%0d data=%h", k, glog[k], wlog[k], g, ed);
      end
    end
  endtask

  task automatic test_last();
    logic [5:0] wen_tr, busy_tr;
    do_reset();
    push_pkt(2, 3, 1, 8'hA0);
    push_pkt(2, 2, 0, 8'hB0);
    for (int c = 0; c < 6; c++) begin
      drive();
      wen_tr[c]  = fifo_w_en;
      busy_tr[c] = busy;
      checks++; if (c > 0 && grant_id !== 2'd2) begin errors++; $display("FAIL last_gid c%0d got %0d exp 2", c, grant_id); end
      commit();
    end
    checks++; if (wen_tr !== 6'b101110) begin errors++; $display("FAIL last_wen_trace got %b exp 101110", wen_tr); end
    checks++; if (busy_tr !== 6'b101110) begin errors++; $display("FAIL last_busy_trace got %b exp 101110", busy_tr); end
    checks++; if (wlog.size() != 4 || wlog[2] !== 8'hA2 || wlog[3] !== 8'hB0) begin
      errors++; $display("FAIL last_data got n=%0d", wlog.size());
    end
  endtask

  task automatic test_full_stall();
    logic [10:0] wen_tr, busy_tr;
    int bad_ready;
    do_reset();
    push_pkt(0, 6, 0, 8'h40);
    bad_ready = 0;
    for (int c = 0; c < 11; c++) begin
      full_drv = (c >= 3 && c <= 7);
      drive();
      wen_tr[c]  = fifo_w_en;
      busy_tr[c] = busy;
      if (full_drv && req_ready !== 4'b0) bad_ready++;
      commit();
    end
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    checks++; if (stall_cnt !== 16'd5) begin errors++; $display("FAIL stall_cnt got %0d exp 5", stall_cnt); end
`endif
    full_drv = 1'b0;
    checks++; if (wen_tr !== 11'b011_0000_0110) begin errors++; $display("FAIL full_wen_trace got %b exp 01100000110", wen_tr); end
    checks++; if (busy_tr !== 11'b011_1111_1110) begin errors++; $display("FAIL full_busy_trace got %b exp 01111111110", busy_tr); end
    checks++; if (bad_ready != 0) begin errors++; $display("FAIL full_ready got %0d cycles with ready exp 0", bad_ready); end
    checks++; if (wlog.size() != 4 || wlog[0] !== 8'h40 || wlog[1] !== 8'h41 || wlog[2] !== 8'h42 || wlog[3] !== 8'h43) begin
      errors++; $display("FAIL full_data got n=%0d", wlog.size());
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    push_pkt(0, 6, 0, 8'h60);
    push_pkt(3, 4, 0, 8'h70);
    en_mask = 4'b0001;
    drive(); commit();
    drive(); commit();
    drive();
    checks++; if (fifo_w_en !== 1'b1 || fifo_wdata !== 8'h61) begin
      errors++; $display("FAIL rstmid_beat2 got wen=%0b data=%h exp wen=1 data=61", fifo_w_en, fifo_wdata);
    end
    #1 wrst = 1'b1;
    #1;
    checks++; if (fifo_w_en !== 1'b0 || req_ready !== 4'b0 || busy !== 1'b0 || grant_id !== 2'd3) begin
      errors++; $display("FAIL rstmid_async got wen=%0b rdy=%b busy=%0b gid=%0d exp 0 0000 0 3", fifo_w_en, req_ready, busy, grant_id);
    end
    @(posedge wclk);
    #1;
    checks++; if (fifo_w_en !== 1'b0) begin errors++; $display("FAIL rstmid_hold_wen got %0b exp 0", fifo_w_en); end
    @(negedge wclk);
    wrst    = 1'b0;
    en_mask = 4'b1001;
    apply_inputs();
    #1;
    commit();
    drive();
    checks++; if (busy !== 1'b1 || grant_id !== 2'd0 || fifo_wdata !== 8'h61) begin
      errors++; $display("FAIL rstmid_rewin got busy=%0b gid=%0d data=%h exp 1 0 61", busy, grant_id, fifo_wdata);
    end
    commit();
    checks++; if (wlog.size() != 2 || wlog[0] !== 8'h60 || wlog[1] !== 8'h61) begin
      errors++; $display("FAIL rstmid_writes got n=%0d exp 2", wlog.size());
    end
  endtask

  task automatic test_random();
    bit            prev_busy, prev_wen, prev_last, prev_vg, end_b, exp_busy, exp_wen;
    int            prev_gid, prev_beats, beats, g;
    logic [NR-1:0] prev_valid, exp_ready;
    logic [8:0]    h;
    do_reset();
    prev_busy = 0; prev_wen = 0; prev_last = 0; prev_vg = 0;
    prev_gid = NR - 1; prev_beats = 0; beats = 0; prev_valid = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (rq[i].size() < 2)
          push_pkt(i, int'($urandom_range(1, 6)), ($urandom_range(0, 3) != 0), int'($urandom_range(0, 255)));
        en_mask[i] = ($urandom_range(0, 99) < 85);
      end
      full_drv = ($urandom_range(0, 99) < 20);
      drive();
      g = int'(grant_id);
      checks++; if (!$onehot0(req_ready)) begin errors++; $display("FAIL rand_onehot c%0d got %b", c, req_ready); end
      exp_ready = (busy && !fifo_full) ? 4'(1 << g) : 4'b0;
      exp_wen   = busy && req_valid[g] && !fifo_full;
      checks++; if (req_ready !== exp_ready || fifo_w_en !== exp_wen) begin
        errors++; $display("FAIL rand_hs c%0d got rdy=%b wen=%0b exp rdy=%b wen=%0b", c, req_ready, fifo_w_en, exp_ready, exp_wen);
      end
      if (exp_wen) begin
        h = rq[g][0];
        checks++; if (fifo_wdata !== h[7:0]) begin
          errors++; $display("FAIL rand_data c%0d got %h exp %h", c, fifo_wdata, h[7:0]);
        end
      end
      if (c > 0) begin
        if (prev_busy) begin
          end_b    = (prev_wen && (prev_last || prev_beats == BL)) || !prev_vg;
          exp_busy = !end_b;
          checks++; if (busy !== exp_busy || (exp_busy && g != prev_gid)) begin
            errors++; $display("FAIL rand_burst c%0d got busy=%0b gid=%0d exp busy=%0b gid=%0d", c, busy, g, exp_busy, prev_gid);
          end
        end else begin
          exp_busy = (prev_valid != '0);
          checks++; if (busy !== exp_busy || (exp_busy && g != rr_pick(prev_gid, prev_valid))) begin
            errors++; $display("FAIL rand_arb c%0d got busy=%0b gid=%0d exp busy=%0b gid=%0d", c, busy, g, exp_busy, rr_pick(prev_gid, prev_valid));
          end
        end
      end
      if (busy && !prev_busy) beats = 0;
      if (fifo_w_en) beats++;
      checks++; if (beats > BL) begin errors++; $display("FAIL rand_len c%0d got %0d beats exp <= %0d", c, beats, BL); end
      prev_busy  = busy;
      prev_gid   = g;
      prev_valid = req_valid;
      prev_wen   = fifo_w_en;
      prev_last  = req_last[g];
      prev_vg    = req_valid[g];
      prev_beats = beats;
      commit();
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    wrst      = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    fifo_full = 1'b0;
    en_mask   = '1;
    full_drv  = 1'b0;
    test_reset();
    test_single_req();
    test_all_valid();
    test_last();
    test_full_stall();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
